// File: rtl/sipo_deserializer.sv
// sipo_deserializer: WIDTH-bit serial-in/parallel-out deserializer with held output, valid/ready handshake and overrun pulse.
// Define PARITY_EN to append one even-parity bit per frame, reported through parity_err.
module sipo_deserializer #(
  parameter int WIDTH = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW = $clog2(WIDTH + 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d,
  input  logic             d_valid,
  input  logic             clr,
  output logic [WIDTH-1:0] q,
  output logic [CW-1:0]    bit_cnt,
  output logic [WIDTH-1:0] pout,
  output logic             pout_valid,
  input  logic             pout_ready,
  output logic             overrun,
  output logic             parity_err
);
`ifdef PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  logic [WIDTH-1:0] q_q, q_d, pout_q, pout_d, shifted, word;
  logic [CW-1:0] cnt_q, cnt_d;
  logic pout_valid_q, pout_valid_d, overrun_q, overrun_d, parity_err_q, parity_err_d;
  logic accept, last, take, data_bit, perr;
  always_comb begin
    accept = d_valid & ~clr;
    last = accept & (cnt_q == CW'(FRAME - 1));
    shifted = MSB_FIRST ? {q_q[WIDTH-2:0], d} : {d, q_q[WIDTH-1:1]};
`ifdef PARITY_EN
    data_bit = cnt_q < CW'(WIDTH);
    word = q_q;
    perr = ^q_q ^ d;
`else
    data_bit = 1'b1;
    word = shifted;
    perr = 1'b0;
`endif
    take = ~pout_valid_q | pout_ready;
    q_d = clr ? '0 : (accept & data_bit) ? shifted : q_q;
    cnt_d = clr ? '0 : accept ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
    pout_d = (last & take) ? word : pout_q;
    parity_err_d = (last & take) ? perr : parity_err_q;
    pout_valid_d = last | (pout_valid_q & ~pout_ready);
    overrun_d = last & ~take;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
      cnt_q <= '0;
      pout_q <= '0;
      pout_valid_q <= 1'b0;
      overrun_q <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      q_q <= q_d;
      cnt_q <= cnt_d;
      pout_q <= pout_d;
      pout_valid_q <= pout_valid_d;
      overrun_q <= overrun_d;
      parity_err_q <= parity_err_d;
    end
  end
  assign q = q_q;
  assign bit_cnt = cnt_q;
  assign pout = pout_q;
  assign pout_valid = pout_valid_q;
  assign overrun = overrun_q;
  assign parity_err = parity_err_q;
endmodule
